// File: rtl/ico_pkg.sv
// Shared constants and types for the increment-controlled oscillator family.
package ico_pkg;

  // Default accumulator/increment widths and the system clock rate
  localparam int ACC_W_DEF = 24;
  localparam int INC_W_DEF = 15;
  localparam int F_CLK     = 40_000_000;

  // Direction of the triangle ramp
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

endpackage

// File: rtl/ico_inc_shadow.sv
// Pending/active increment registers. Writes land in the pending register
// and are promoted to the active slope only when the accumulator allows it,
// so the triangle never changes slope part-way through a period.
module ico_inc_shadow
  import ico_pkg::*;
#(
  parameter int INC_W = INC_W_DEF
) (
  input  logic             clk40MHz,
  input  logic             rst,
  input  logic [INC_W-1:0] inc_in,
  input  logic             inc_wr,
  input  logic             apply,
  output logic [INC_W-1:0] inc_act,
  output logic             inc_busy
);

  logic [INC_W-1:0] inc_pend;

  // Capture writes into pending; promote pending to active on an apply cycle.
  // A write landing on an apply cycle stays pending for the next opportunity.
  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      inc_pend <= '0;
      inc_act  <= '0;
      inc_busy <= 1'b0;
    end else begin
      if (apply && inc_busy) begin
        inc_act  <= inc_pend;
        inc_busy <= 1'b0;
      end
      if (inc_wr) begin
        inc_pend <= inc_in;
        inc_busy <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ico_gen.sv
// Triangle up/down accumulator oscillator. The count ramps between 0 and
// 2^(ACC_W-1); the direction bit is the square output, so the output
// frequency is inc*f_clk/2^ACC_W. Also provides PWM, a period-start sync
// pulse and readback of the running count.
module ico_gen
  import ico_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int INC_W = INC_W_DEF
) (
  input  logic             clk40MHz,
  input  logic             rst,
  input  logic             en,
  input  logic [INC_W-1:0] inc_in,
  input  logic             inc_wr,
  input  logic [ACC_W-2:0] duty_thr,
  output logic             out_sq,
  output logic             out_pwm,
  output logic             sync,
  output logic             inc_busy,
  output logic [ACC_W-1:0] count
);

  // The reflection arithmetic needs at least one guard bit above the slope
  if (INC_W > ACC_W - 2) begin : g_param_check
    $fatal(1, "ico_gen: INC_W must be <= ACC_W-2");
  end

  localparam logic [ACC_W-1:0] ACC_ONE = {{(ACC_W-1){1'b0}}, 1'b1};

  // A sum with its top bit set has crossed a turning point: reflect it
  // (two's-complement negate) and report that the direction must flip.
  function automatic logic [ACC_W:0] fold(input logic [ACC_W-1:0] sum);
    logic [ACC_W-1:0] refl;
    refl = ~(sum - ACC_ONE);
    return sum[ACC_W-1] ? {1'b1, refl} : {1'b0, sum};
  endfunction

  dir_t             up;
  dir_t             up_next;
  logic [INC_W-1:0] inc_act;
  logic [ACC_W-1:0] delta;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] count_fold;
  logic             flip;
  logic             fold_du;
  logic             apply;

  ico_inc_shadow #(
    .INC_W (INC_W)
  ) u_shadow (
    .clk40MHz (clk40MHz),
    .rst      (rst),
    .inc_in   (inc_in),
    .inc_wr   (inc_wr),
    .apply    (apply),
    .inc_act  (inc_act),
    .inc_busy (inc_busy)
  );

  assign delta = {{(ACC_W-INC_W){1'b0}}, inc_act};
  assign sum   = (up == DIR_UP) ? count + delta : count - delta;
  assign {flip, count_fold} = fold(sum);

  // Next direction and the safe points at which a new slope may be applied:
  // period start (down-to-up fold), any held cycle, or idle at zero going up.
  always_comb begin
    up_next = up;
    if (flip) begin
      up_next = (up == DIR_UP) ? DIR_DOWN : DIR_UP;
    end
    fold_du = en && flip && (up == DIR_DOWN);
    apply   = fold_du || !en || ((count == '0) && (up == DIR_UP));
  end

  // Accumulator, direction and registered outputs; everything holds while
  // disabled except sync, which is only ever a single-cycle pulse.
  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      count   <= '0;
      up      <= DIR_UP;
      out_sq  <= 1'b0;
      out_pwm <= 1'b0;
      sync    <= 1'b0;
    end else if (en) begin
      count   <= count_fold;
      up      <= up_next;
      out_sq  <= (up_next == DIR_UP);
      out_pwm <= (count_fold < {1'b0, duty_thr});
      sync    <= fold_du;
    end else begin
      sync    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ico_gen.sv
// Bench for ico_gen: a small ACC_W=8 instance checked cycle by cycle against
// a hand table and a reference model through an expectation queue, plus a
// default-width instance whose sync spacing is measured.
module tb_ico_gen;

  localparam int HALF = 128;
  localparam int FULL = 256;

  typedef struct packed {
    logic [7:0] cnt;
    logic       sq;
    logic       pwm;
    logic       syn;
    logic       busy;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       en;
    logic       wr;
    logic [5:0] inc;
    exp_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [5:0] inc_in = '0;
  logic       inc_wr = 1'b0;
  logic [6:0] duty_thr = 7'd32;
  logic       out_sq, out_pwm, sync, inc_busy;
  logic [7:0] count;

  logic        rst2 = 1'b1;
  logic        en2 = 1'b1;
  logic [14:0] inc_in2 = '0;
  logic        inc_wr2 = 1'b0;
  logic [22:0] duty_thr2 = '0;
  logic        out_sq2, out_pwm2, sync2, inc_busy2;
  logic [23:0] count2;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  vec_t tbl[21];

  int m_count, m_act, m_pend;
  bit m_up, m_busy, m_sq, m_pwm, m_sync;

  ico_gen #(.ACC_W(8), .INC_W(6)) dut (
    .clk40MHz (clk),
    .rst      (rst),
    .en       (en),
    .inc_in   (inc_in),
    .inc_wr   (inc_wr),
    .duty_thr (duty_thr),
    .out_sq   (out_sq),
    .out_pwm  (out_pwm),
    .sync     (sync),
    .inc_busy (inc_busy),
    .count    (count)
  );

  ico_gen dut2 (
    .clk40MHz (clk),
    .rst      (rst2),
    .en       (en2),
    .inc_in   (inc_in2),
    .inc_wr   (inc_wr2),
    .duty_thr (duty_thr2),
    .out_sq   (out_sq2),
    .out_pwm  (out_pwm2),
    .sync     (sync2),
    .inc_busy (inc_busy2),
    .count    (count2)
  );

  // Free-running clock shared by both instances
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic e, input logic w,
                              input logic [5:0] i, input int c, input logic sq,
                              input logic pwm, input logic syn, input logic busy);
    vec_t v;
    v.rst = r; v.en = e; v.wr = w; v.inc = i;
    v.exp.cnt = c[7:0]; v.exp.sq = sq; v.exp.pwm = pwm;
    v.exp.syn = syn; v.exp.busy = busy;
    return v;
  endfunction

  // Reference model: unfolded triangle with explicit reflection at 128 and 0
  task automatic modelStep(input logic r, input logic e, input logic w,
                           input logic [5:0] i, output exp_t ex);
    int n, nc;
    bit nu, du, app;
    if (r) begin
      m_count = 0; m_up = 1; m_act = 0; m_pend = 0; m_busy = 0;
      m_sq = 0; m_pwm = 0; m_sync = 0;
    end else begin
      du = 0; nc = m_count; nu = m_up;
      if (e) begin
        if (m_up) begin
          n = m_count + m_act;
          if (n >= HALF) begin nc = FULL - n; nu = 0; end
          else nc = n;
        end else begin
          n = m_count - m_act;
          if (n < 0) begin nc = -n; nu = 1; du = 1; end
          else nc = n;
        end
      end
      app = du || !e || (m_count == 0 && m_up);
      if (app && m_busy) begin m_act = m_pend; m_busy = 0; end
      if (w) begin m_pend = int'(i); m_busy = 1; end
      if (e) begin
        m_count = nc; m_up = nu; m_sq = nu;
        m_pwm = (nc < int'(duty_thr)); m_sync = du;
      end else begin
        m_sync = 0;
      end
    end
    ex.cnt = m_count[7:0]; ex.sq = m_sq; ex.pwm = m_pwm;
    ex.syn = m_sync; ex.busy = m_busy;
  endtask

  task automatic checkOutput(input string tag);
    exp_t got, want;
    got = {count, out_sq, out_pwm, sync, inc_busy};
    want = exp_q.pop_front();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s #%0d: got cnt=%0d sq=%b pwm=%b sync=%b busy=%b, want cnt=%0d sq=%b pwm=%b sync=%b busy=%b",
               tag, vectors, got.cnt, got.sq, got.pwm, got.syn, got.busy,
               want.cnt, want.sq, want.pwm, want.syn, want.busy);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic w,
                               input logic [5:0] i, input exp_t ex, input string tag);
    rst = r; en = e; inc_wr = w; inc_in = i;
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic stepModel(input logic r, input logic e, input logic w,
                           input logic [5:0] i, input string tag);
    exp_t ex;
    modelStep(r, e, w, i, ex);
    applyStimulus(r, e, w, i, ex, tag);
  endtask

  // Main sequence on the ACC_W=8 instance, then sync spacing on the default one
  initial begin
    exp_t ex;
    int n;
    bit seen;

    tbl[0]  = mk(1, 0, 0, 0,    0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 16,   0, 1, 1, 0, 1);
    tbl[2]  = mk(0, 1, 0, 0,    0, 1, 1, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0,   16, 1, 1, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0,   32, 1, 0, 0, 0);
    tbl[5]  = mk(0, 1, 0, 0,   48, 1, 0, 0, 0);
    tbl[6]  = mk(0, 1, 0, 0,   64, 1, 0, 0, 0);
    tbl[7]  = mk(0, 1, 0, 0,   80, 1, 0, 0, 0);
    tbl[8]  = mk(0, 1, 0, 0,   96, 1, 0, 0, 0);
    tbl[9]  = mk(0, 1, 0, 0,  112, 1, 0, 0, 0);
    tbl[10] = mk(0, 1, 0, 0,  128, 0, 0, 0, 0);
    tbl[11] = mk(0, 1, 0, 0,  112, 0, 0, 0, 0);
    tbl[12] = mk(0, 1, 0, 0,   96, 0, 0, 0, 0);
    tbl[13] = mk(0, 1, 0, 0,   80, 0, 0, 0, 0);
    tbl[14] = mk(0, 1, 0, 0,   64, 0, 0, 0, 0);
    tbl[15] = mk(0, 1, 0, 0,   48, 0, 0, 0, 0);
    tbl[16] = mk(0, 1, 0, 0,   32, 0, 0, 0, 0);
    tbl[17] = mk(0, 1, 0, 0,   16, 0, 1, 0, 0);
    tbl[18] = mk(0, 1, 0, 0,    0, 0, 1, 0, 0);
    tbl[19] = mk(0, 1, 0, 0,   16, 1, 1, 1, 0);
    tbl[20] = mk(0, 1, 0, 0,   32, 1, 0, 0, 0);

    $display("[TB] table: reset, inc=16 first period");
    for (int k = 0; k < 21; k++) begin
      modelStep(tbl[k].rst, tbl[k].en, tbl[k].wr, tbl[k].inc, ex);
      applyStimulus(tbl[k].rst, tbl[k].en, tbl[k].wr, tbl[k].inc, tbl[k].exp, "table");
    end

    for (int k = 0; k < 40; k++) stepModel(0, 1, 0, 0, "run16");

    $display("[TB] increment change mid up-ramp");
    for (int k = 0; k < 32 && !(m_up && m_count == 48); k++) stepModel(0, 1, 0, 0, "seek_up");
    stepModel(0, 1, 1, 6'd32, "wr32");
    for (int k = 0; k < 40; k++) stepModel(0, 1, 0, 0, "run32");

    $display("[TB] hold with pending increment");
    stepModel(0, 1, 1, 6'd16, "wr16");
    stepModel(0, 1, 0, 0, "pre_hold");
    stepModel(0, 1, 0, 0, "pre_hold");
    for (int k = 0; k < 5; k++) stepModel(0, 0, 0, 0, "hold");
    for (int k = 0; k < 20; k++) stepModel(0, 1, 0, 0, "resume");

    $display("[TB] reset mid down-ramp with write");
    for (int k = 0; k < 40 && !(!m_up && m_count >= 32 && m_count <= 96); k++)
      stepModel(0, 1, 0, 0, "seek_dn");
    stepModel(1, 1, 1, 6'd40, "rst_wr");
    for (int k = 0; k < 4; k++) stepModel(0, 1, 0, 0, "post_rst");
    stepModel(0, 1, 1, 6'd8, "wr8");
    for (int k = 0; k < 40; k++) stepModel(0, 1, 0, 0, "run8");

    $display("[TB] random traffic");
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 19) == 0) duty_thr = 7'($urandom_range(0, 127));
      stepModel(logic'($urandom_range(0, 99) == 0),
                logic'($urandom_range(0, 9) != 0),
                logic'($urandom_range(0, 15) == 0),
                6'($urandom_range(0, 63)), "random");
    end

    $display("[TB] default width, inc=13002 sync spacing");
    @(posedge clk); #1;
    rst2 = 1'b0; inc_in2 = 15'd13002; inc_wr2 = 1'b1;
    @(posedge clk); #1;
    inc_wr2 = 1'b0;
    seen = 0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(posedge clk); #1;
      seen = sync2;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("[TB] FAIL first_sync: got none within 3000 cycles, want one");
    end else begin
      for (int p = 0; p < 8; p++) begin
        n = 0;
        do begin
          @(posedge clk); #1;
          n++;
        end while (!sync2 && n < 2000);
        vectors++;
        if (n != 1290 && n != 1291) begin
          miscompares++;
          $display("[TB] FAIL sync_interval: got %0d cycles, want 1290 or 1291", n);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
